zion_riscv_bj_resolve_pipe: RTL and testbench

//   Pipelined branch/jump resolution unit for RV32I/RV64I cores. Replaces the combinational BJ execute helpers.

---
 rtl/zion_riscv_bj_resolve_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_zion_riscv_bj_resolve_pipe.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zion_riscv_bj_resolve_pipe.sv
// Pipelined RV32I/RV64I branch/jump resolver: taken, next/link PC, mispredict and misalignment.
// Optional ZION_BJ_PERF_CNT_EN adds saturating result and mispredict counters.
module zion_riscv_bj_resolve_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 1,
    parameter int unsigned CEXT   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iFlush,
    input  logic            iValid,
    output logic            oReady,
    input  logic [1:0]      iKind,
    input  logic [2:0]      iFunct3,
    input  logic            iRvc,
    input  logic [XLEN-1:0] iPc,
    input  logic [XLEN-1:0] iS1,
    input  logic [XLEN-1:0] iS2,
    input  logic [XLEN-1:0] iOffset,
    input  logic            iPredTaken,
    input  logic [XLEN-1:0] iPredTgt,
    output logic            oValid,
    input  logic            iReady,
    output logic            oTaken,
    output logic [XLEN-1:0] oNextPc,
    output logic [XLEN-1:0] oLinkPc,
    output logic            oMispredict,
    output logic            oMisalign
`ifdef ZION_BJ_PERF_CNT_EN
    ,
    output logic [31:0]     oBjCnt,
    output logic [31:0]     oMispCnt
`endif
);

    function automatic logic f_taken(input logic [1:0] kind, input logic [2:0] f3,
                                     input logic eq, input logic lt);
        logic t;
        t = 1'b0;
        case (kind)
            2'b01, 2'b10: t = 1'b1;
            2'b00: begin
                case (f3)
                    3'b000:         t = eq;
                    3'b001:         t = !eq;
                    3'b100, 3'b110: t = lt;
                    3'b101, 3'b111: t = !lt;
                    default:        t = 1'b0;
                endcase
            end
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    logic            w_accept, w_out_fire, w_load_out;
    logic            w_signed, w_eq, w_lt;
    logic [XLEN:0]   w_cmp_a, w_cmp_b;
    logic [XLEN-1:0] w_sum, w_tgt, w_fall;

    logic [1:0]      w_b_kind;
    logic [2:0]      w_b_f3;
    logic            w_b_eq, w_b_lt, w_b_pt;
    logic [XLEN-1:0] w_b_tgt, w_b_fall, w_b_ptgt;
    logic            w_taken, w_misalign, w_misp;
    logic [XLEN-1:0] w_npc;

    logic            r_o_valid, r_o_taken, r_o_misp, r_o_mis;
    logic [XLEN-1:0] r_o_npc, r_o_lpc;

    assign w_accept   = iValid && oReady;
    assign w_out_fire = r_o_valid && iReady;

    // One shared XLEN+1 comparator: extend with the sign bit only for BLT/BGE.
    assign w_signed = !iFunct3[1];
    assign w_cmp_a  = {w_signed & iS1[XLEN-1], iS1};
    assign w_cmp_b  = {w_signed & iS2[XLEN-1], iS2};
    assign w_lt     = $signed(w_cmp_a) < $signed(w_cmp_b);
    assign w_eq     = (iS1 == iS2);
    assign w_sum    = ((iKind == 2'b10) ? iS1 : iPc) + iOffset;
    assign w_tgt    = (iKind == 2'b10) ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
    assign w_fall   = iPc + (((CEXT != 0) && iRvc) ? XLEN'(2) : XLEN'(4));

    generate
        if (STAGES == 1) begin : g_one
            assign w_b_kind   = iKind;
            assign w_b_f3     = iFunct3;
            assign w_b_eq     = w_eq;
            assign w_b_lt     = w_lt;
            assign w_b_tgt    = w_tgt;
            assign w_b_fall   = w_fall;
            assign w_b_pt     = iPredTaken;
            assign w_b_ptgt   = iPredTgt;
            assign w_load_out = w_accept;
            assign oReady     = !r_o_valid || w_out_fire;
        end else begin : g_two
            logic            r_p_valid, r_p_eq, r_p_lt, r_p_pt;
            logic [1:0]      r_p_kind;
            logic [2:0]      r_p_f3;
            logic [XLEN-1:0] r_p_tgt, r_p_fall, r_p_ptgt;
            logic            w_adv;

            assign w_adv      = r_p_valid && (!r_o_valid || w_out_fire);
            assign w_load_out = w_adv;
            assign oReady     = !r_p_valid || w_adv;

            always_ff @(posedge clk) begin
                if (!rst_n || iFlush) begin
                    r_p_valid <= 1'b0;
                end else if (w_accept) begin
                    r_p_valid <= 1'b1;
                end else if (w_adv) begin
                    r_p_valid <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_p_eq   <= 1'b0;
                    r_p_lt   <= 1'b0;
                    r_p_pt   <= 1'b0;
                    r_p_kind <= 2'b00;
                    r_p_f3   <= 3'b000;
                    r_p_tgt  <= '0;
                    r_p_fall <= '0;
                    r_p_ptgt <= '0;
                end else if (w_accept) begin
                    r_p_eq   <= w_eq;
                    r_p_lt   <= w_lt;
                    r_p_pt   <= iPredTaken;
                    r_p_kind <= iKind;
                    r_p_f3   <= iFunct3;
                    r_p_tgt  <= w_tgt;
                    r_p_fall <= w_fall;
                    r_p_ptgt <= iPredTgt;
                end
            end

            assign w_b_kind = r_p_kind;
            assign w_b_f3   = r_p_f3;
            assign w_b_eq   = r_p_eq;
            assign w_b_lt   = r_p_lt;
            assign w_b_tgt  = r_p_tgt;
            assign w_b_fall = r_p_fall;
            assign w_b_pt   = r_p_pt;
            assign w_b_ptgt = r_p_ptgt;
        end
    endgenerate

    // Misalignment is an exception, so it suppresses the redirect request.
    assign w_taken    = f_taken(w_b_kind, w_b_f3, w_b_eq, w_b_lt);
    assign w_misalign = (CEXT == 0) && w_taken && w_b_tgt[1];
    assign w_misp     = !w_misalign &&
                        ((w_taken != w_b_pt) || (w_taken && (w_b_tgt != w_b_ptgt)));
    assign w_npc      = w_taken ? w_b_tgt : w_b_fall;

    always_ff @(posedge clk) begin
        if (!rst_n || iFlush) begin
            r_o_valid <= 1'b0;
        end else if (w_load_out) begin
            r_o_valid <= 1'b1;
        end else if (w_out_fire) begin
            r_o_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_o_taken <= 1'b0;
            r_o_misp  <= 1'b0;
            r_o_mis   <= 1'b0;
            r_o_npc   <= '0;
            r_o_lpc   <= '0;
        end else if (w_load_out) begin
            r_o_taken <= w_taken;
            r_o_misp  <= w_misp;
            r_o_mis   <= w_misalign;
            r_o_npc   <= w_npc;
            r_o_lpc   <= w_b_fall;
        end
    end

    assign oValid      = r_o_valid;
    assign oTaken      = r_o_taken;
    assign oNextPc     = r_o_npc;
    assign oLinkPc     = r_o_lpc;
    assign oMispredict = r_o_misp;
    assign oMisalign   = r_o_mis;

`ifdef ZION_BJ_PERF_CNT_EN
    logic [31:0] r_bj_cnt, r_misp_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bj_cnt   <= '0;
            r_misp_cnt <= '0;
        end else if (w_out_fire) begin
            if (r_bj_cnt != 32'hFFFF_FFFF) begin
                r_bj_cnt <= r_bj_cnt + 32'd1;
            end
            if (r_o_misp && (r_misp_cnt != 32'hFFFF_FFFF)) begin
                r_misp_cnt <= r_misp_cnt + 32'd1;
            end
        end
    end

    assign oBjCnt   = r_bj_cnt;
    assign oMispCnt = r_misp_cnt;
`endif

endmodule

// File: tb/tb_zion_riscv_bj_resolve_pipe.sv
// Scoreboard bench: dut0 is STAGES=1/CEXT=0, dut1 is STAGES=2/CEXT=1, both XLEN=32.
module tb_zion_riscv_bj_resolve_pipe;

    typedef struct packed {
        logic [1:0]  kind;
        logic [2:0]  f3;
        logic        rvc;
        logic [31:0] pc;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] off;
        logic        pt;
        logic [31:0] ptgt;
    } op_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] npc;
        logic [31:0] lpc;
        logic        misp;
        logic        mis;
        int          acc;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    op_t         op     [2];
    logic        v_i    [2];
    logic        rdy_i  [2];
    logic        fl_i   [2];
    logic        o_rdy  [2];
    logic        o_v    [2];
    logic        o_tk   [2];
    logic        o_misp [2];
    logic        o_mis  [2];
    logic [31:0] o_npc  [2];
    logic [31:0] o_lpc  [2];
`ifdef ZION_BJ_PERF_CNT_EN
    logic [31:0] o_bj   [2];
    logic [31:0] o_mc   [2];
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    res_t q0[$];
    res_t q1[$];
    int unsigned m_bj [2];
    int unsigned m_mc [2];

    always @(posedge clk) cyc <= cyc + 1;

    zion_riscv_bj_resolve_pipe #(.XLEN(32), .STAGES(1), .CEXT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .iFlush(fl_i[0]), .iValid(v_i[0]), .oReady(o_rdy[0]),
        .iKind(op[0].kind), .iFunct3(op[0].f3), .iRvc(op[0].rvc), .iPc(op[0].pc),
        .iS1(op[0].s1), .iS2(op[0].s2), .iOffset(op[0].off), .iPredTaken(op[0].pt),
        .iPredTgt(op[0].ptgt), .oValid(o_v[0]), .iReady(rdy_i[0]), .oTaken(o_tk[0]),
        .oNextPc(o_npc[0]), .oLinkPc(o_lpc[0]), .oMispredict(o_misp[0]), .oMisalign(o_mis[0])
`ifdef ZION_BJ_PERF_CNT_EN
        , .oBjCnt(o_bj[0]), .oMispCnt(o_mc[0])
`endif
    );

    zion_riscv_bj_resolve_pipe #(.XLEN(32), .STAGES(2), .CEXT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .iFlush(fl_i[1]), .iValid(v_i[1]), .oReady(o_rdy[1]),
        .iKind(op[1].kind), .iFunct3(op[1].f3), .iRvc(op[1].rvc), .iPc(op[1].pc),
        .iS1(op[1].s1), .iS2(op[1].s2), .iOffset(op[1].off), .iPredTaken(op[1].pt),
        .iPredTgt(op[1].ptgt), .oValid(o_v[1]), .iReady(rdy_i[1]), .oTaken(o_tk[1]),
        .oNextPc(o_npc[1]), .oLinkPc(o_lpc[1]), .oMispredict(o_misp[1]), .oMisalign(o_mis[1])
`ifdef ZION_BJ_PERF_CNT_EN
        , .oBjCnt(o_bj[1]), .oMispCnt(o_mc[1])
`endif
    );

    function automatic int stages_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    // Reference: architectural BJ semantics in plain 32-bit arithmetic.
    function automatic res_t ref_model(input op_t o, input bit cext);
        res_t r;
        logic [31:0] tgt, fall;
        bit tk, mis;
        r = '0;
        tgt = (o.kind == 2'b10) ? ((o.s1 + o.off) & 32'hFFFF_FFFE) : (o.pc + o.off);
        fall = o.pc + ((cext && o.rvc) ? 32'd2 : 32'd4);
        tk = 0;
        if (o.kind == 2'b01 || o.kind == 2'b10) begin
            tk = 1;
        end else if (o.kind == 2'b00) begin
            case (o.f3)
                3'd0: tk = (o.s1 == o.s2);
                3'd1: tk = (o.s1 != o.s2);
                3'd4: tk = ($signed(o.s1) < $signed(o.s2));
                3'd5: tk = ($signed(o.s1) >= $signed(o.s2));
                3'd6: tk = (o.s1 < o.s2);
                3'd7: tk = (o.s1 >= o.s2);
                default: tk = 0;
            endcase
        end
        mis = tk && !cext && tgt[1];
        r.taken = tk;
        r.mis = mis;
        r.npc = tk ? tgt : fall;
        r.lpc = fall;
        r.misp = !mis && ((tk != o.pt) || (tk && (tgt != o.ptgt)));
        return r;
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input int k);
        total++;
        bad++;
        $display("FAIL %s dut%0d: bound expired (cycle %0d)", name, k, cyc);
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic res_t qfront(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int k);
        if (k == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endtask

    task automatic qpush(input int k, input res_t r);
        if (k == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask

    task automatic qclear(input int k);
        if (k == 0) q0.delete();
        else q1.delete();
    endtask

    // Monitor: an in-flight op is visible once STAGES cycles have passed since it was accepted.
    task automatic mon(input int k);
        res_t head;
        res_t r;
        int n;
        bit mv, er;
        head = '0;
        if (!rst_n) begin
            qclear(k);
            m_bj[k] = 0;
            m_mc[k] = 0;
            return;
        end
        n = qsize(k);
        if (n > 0) head = qfront(k);
        mv = (n > 0) && (cyc >= head.acc + stages_of(k));
        er = (n < stages_of(k)) || (mv && rdy_i[k]);
        chk("ovalid", k, 64'(o_v[k]), 64'(mv));
        chk("oready", k, 64'(o_rdy[k]), 64'(er));
`ifdef ZION_BJ_PERF_CNT_EN
        chk("bjcnt", k, 64'(o_bj[k]), 64'(m_bj[k]));
        chk("mispcnt", k, 64'(o_mc[k]), 64'(m_mc[k]));
`endif
        if (o_v[k] && mv) begin
            chk("taken", k, 64'(o_tk[k]), 64'(head.taken));
            chk("nextpc", k, 64'(o_npc[k]), 64'(head.npc));
            chk("linkpc", k, 64'(o_lpc[k]), 64'(head.lpc));
            chk("mispredict", k, 64'(o_misp[k]), 64'(head.misp));
            chk("misalign", k, 64'(o_mis[k]), 64'(head.mis));
        end
        if (mv && rdy_i[k]) begin
            qpop(k);
            m_bj[k]++;
            if (head.misp) m_mc[k]++;
        end
        if (fl_i[k]) begin
            qclear(k);
        end else if (v_i[k] && o_rdy[k]) begin
            r = ref_model(op[k], k == 1);
            r.acc = cyc;
            qpush(k, r);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) mon(k);
    end

    function automatic op_t mk(input logic [1:0] kind, input logic [2:0] f3, input logic rvc,
                               input logic [31:0] pc, input logic [31:0] s1, input logic [31:0] s2,
                               input logic [31:0] off, input logic pt, input logic [31:0] ptgt);
        op_t o;
        o.kind = kind; o.f3 = f3; o.rvc = rvc; o.pc = pc; o.s1 = s1; o.s2 = s2;
        o.off = off; o.pt = pt; o.ptgt = ptgt;
        return o;
    endfunction

    function automatic op_t rand_op(input int k);
        op_t o;
        int r;
        r = int'($urandom % 20);
        o.kind = (r < 10) ? 2'b00 : (r < 14) ? 2'b01 : (r < 18) ? 2'b10 : 2'b11;
        o.f3 = 3'($urandom % 8);
        o.rvc = 1'($urandom % 2);
        o.pc = $urandom & ((k == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
        case ($urandom % 4)
            0: o.s1 = 32'h8000_0000;
            1: o.s1 = 32'h7FFF_FFFF;
            default: o.s1 = $urandom;
        endcase
        case ($urandom % 4)
            0: o.s2 = o.s1;
            1: o.s2 = o.s1 + 32'd1;
            2: o.s2 = o.s1 - 32'd1;
            default: o.s2 = $urandom;
        endcase
        o.off = 32'($urandom_range(0, 8191)) - 32'd4096;
        if (o.kind != 2'b10) o.off = o.off & 32'hFFFF_FFFE;
        o.pt = 1'($urandom % 2);
        if ($urandom % 2 == 0)
            o.ptgt = (o.kind == 2'b10) ? ((o.s1 + o.off) & 32'hFFFF_FFFE) : (o.pc + o.off);
        else
            o.ptgt = $urandom;
        return o;
    endfunction

    task automatic set_idle(input int k);
        v_i[k] = 1'b0;
        fl_i[k] = 1'b0;
        rdy_i[k] = 1'b1;
        op[k] = '0;
    endtask

    task automatic send(input int k, input op_t o);
        bit got;
        got = 0;
        op[k] = o;
        v_i[k] = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = o_rdy[k] && !fl_i[k];
            @(posedge clk);
            #1;
        end
        if (!got) fail("send_timeout", k);
        v_i[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        v_i[k] = 1'b0;
        fl_i[k] = 1'b0;
        rdy_i[k] = 1'b1;
        for (int i = 0; i < 30 && qsize(k) != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (qsize(k) != 0) fail("drain", k);
    endtask

    // mode 0: back-to-back with iReady low for 3 cycles; 1: random handshakes; 2: plus flushes.
    task automatic stream(input int k, input int nops, input int mode);
        op_t cur;
        int left, c;
        bit used;
        cur = rand_op(k);
        left = nops;
        c = 0;
        while (left > 0 && c < 5000) begin
            op[k] = cur;
            v_i[k] = (mode == 0) ? 1'b1 : 1'($urandom % 4 != 0);
            rdy_i[k] = (mode == 0) ? 1'(!(c >= 3 && c <= 5)) : 1'($urandom % 3 != 0);
            fl_i[k] = (mode == 2) ? 1'($urandom % 20 == 0) : 1'b0;
            @(negedge clk);
            used = v_i[k] && (fl_i[k] || o_rdy[k]);
            @(posedge clk);
            #1;
            if (used) begin
                left--;
                cur = rand_op(k);
            end
            c++;
        end
        if (left > 0) fail("stream_timeout", k);
        set_idle(k);
        drain(k);
    endtask

    task automatic check_rst();
        for (int k = 0; k < 2; k++) begin
            chk("rst_ovalid", k, 64'(o_v[k]), 64'd0);
            chk("rst_taken", k, 64'(o_tk[k]), 64'd0);
            chk("rst_nextpc", k, 64'(o_npc[k]), 64'd0);
            chk("rst_linkpc", k, 64'(o_lpc[k]), 64'd0);
            chk("rst_misp", k, 64'(o_misp[k]), 64'd0);
            chk("rst_misalign", k, 64'(o_mis[k]), 64'd0);
`ifdef ZION_BJ_PERF_CNT_EN
            chk("rst_bjcnt", k, 64'(o_bj[k]), 64'd0);
            chk("rst_mispcnt", k, 64'(o_mc[k]), 64'd0);
`endif
        end
    endtask

    task automatic flush_test(input int k);
        rdy_i[k] = 1'b0;
        for (int i = 0; i < stages_of(k); i++) send(k, rand_op(k));
        op[k] = rand_op(k);
        v_i[k] = 1'b1;
        fl_i[k] = 1'b1;
        @(posedge clk);
        #1;
        v_i[k] = 1'b0;
        fl_i[k] = 1'b0;
        @(negedge clk);
        chk("flush_ovalid", k, 64'(o_v[k]), 64'd0);
        @(posedge clk);
        #1;
        rdy_i[k] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    op_t dir [13];

    initial begin
        for (int k = 0; k < 2; k++) set_idle(k);
        dir[0]  = mk(2'b00, 3'd0, 1'b0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0);
        dir[1]  = mk(2'b00, 3'd4, 1'b0, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h0);
        dir[2]  = mk(2'b00, 3'd6, 1'b0, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h0);
        dir[3]  = mk(2'b10, 3'd0, 1'b0, 32'h300, 32'h1003, 32'd0, 32'h0, 1'b1, 32'h1002);
        dir[4]  = mk(2'b10, 3'd0, 1'b1, 32'h300, 32'h1003, 32'd0, 32'h0, 1'b1, 32'h1002);
        dir[5]  = mk(2'b01, 3'd0, 1'b0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8, 1'b1, 32'h4);
        dir[6]  = mk(2'b00, 3'd2, 1'b0, 32'h400, 32'd1, 32'd1, 32'h10, 1'b1, 32'h410);
        dir[7]  = mk(2'b11, 3'd0, 1'b0, 32'h400, 32'd1, 32'd1, 32'h10, 1'b0, 32'h0);
        dir[8]  = mk(2'b00, 3'd1, 1'b0, 32'h400, 32'd7, 32'd7, 32'hFFFF_FFFC, 1'b1, 32'h3FC);
        dir[9]  = mk(2'b00, 3'd5, 1'b0, 32'h500, 32'h8000_0000, 32'h7FFF_FFFF, 32'h10, 1'b1,
                     32'h510);
        dir[10] = mk(2'b00, 3'd7, 1'b0, 32'h500, 32'h8000_0000, 32'h7FFF_FFFF, 32'h10, 1'b1,
                     32'h510);
        dir[11] = mk(2'b00, 3'd0, 1'b0, 32'h600, 32'd1, 32'd2, 32'h6, 1'b1, 32'h606);
        dir[12] = mk(2'b01, 3'd0, 1'b0, 32'h700, 32'd0, 32'd0, 32'h6, 1'b1, 32'h706);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_rst();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("ready_after_rst", k, 64'(o_rdy[k]), 64'd1);
        @(posedge clk);
        #1;

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 13; i++) send(k, dir[i]);
            drain(k);
        end

        for (int k = 0; k < 2; k++) stream(k, 8, 0);
        for (int k = 0; k < 2; k++) flush_test(k);

        // Reset while both units hold a stalled result.
        for (int k = 0; k < 2; k++) begin
            rdy_i[k] = 1'b0;
            send(k, rand_op(k));
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_rst();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) rdy_i[k] = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        for (int k = 0; k < 2; k++) stream(k, 60, 1);
        for (int k = 0; k < 2; k++) stream(k, 300, 2);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
